seq_add_sub: RTL and testbench

//   Parametrised multi-cycle two's-complement adder/subtractor. Adds or subtracts N-bit operands CHUNK bits per clock, LSB chunk first.

---
 rtl/seq_add_sub.sv | 113 +++++++++++
 tb/tb_seq_add_sub.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_add_sub.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with the inter-chunk carry held in a register. Results only update on completion.
//
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | one chunk added per cycle, idx selects the chunk
//   S_DONE | result just written, done high; start here is accepted back-to-back
`timescale 1ns/1ps
module seq_add_sub #(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf,
  output logic         zero
);

  localparam int L  = N / CHUNK;
  localparam int IW = (L > 1) ? $clog2(L) : 1;

  generate
    if (N % CHUNK != 0) begin : g_chunk_check
      $error("seq_add_sub: N must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [N-1:0]   acc;
  logic           carry;
  logic [IW-1:0]  idx;

  logic [31:0]    shamt;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0] chunk_sum;
  logic [N-1:0]   chunk_mask;
  logic [N-1:0]   acc_next;
  logic           last;

  // Chunk selection by shifting keeps the index width independent of N and CHUNK.
  always_comb begin
    shamt      = 32'(idx) * 32'(CHUNK);
    a_chunk    = CHUNK'(a_q >> shamt);
    b_chunk    = CHUNK'(b_q >> shamt);
    chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    chunk_mask = N'({CHUNK{1'b1}}) << shamt;
    acc_next   = (acc & ~chunk_mask) | (N'(chunk_sum[CHUNK-1:0]) << shamt);
    last       = (idx == IW'(L - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= sub ? ~B : B;
            carry <= sub;
            idx   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          carry <= chunk_sum[CHUNK];
          idx   <= idx + 1'b1;
          if (last) begin
            sum   <= acc_next;
            c_out <= chunk_sum[CHUNK];
            ovf   <= (a_q[N-1] == b_q[N-1]) && (acc_next[N-1] != a_q[N-1]);
            zero  <= (acc_next == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub: three instances (CHUNK 4, 16, 1) share stimulus; a per-instance
// cycle model with a result queue predicts every output each cycle.
`timescale 1ns/1ps
module tb_seq_add_sub;

  localparam int NI = 3;
  localparam int LAT [NI] = '{4, 1, 16};

  typedef struct packed {
    logic [15:0] sum;
    logic        c;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] A;
  logic [15:0] B;

  logic        busy_v [NI];
  logic        done_v [NI];
  logic [15:0] sum_v  [NI];
  logic        c_v    [NI];
  logic        ovf_v  [NI];
  logic        zero_v [NI];

  int   checks   = 0;
  int   failures = 0;

  int   cnt      [NI];
  int   ops_done [NI];
  logic exp_done [NI];
  res_t held     [NI];
  res_t q        [NI][$];

  always #5 clk = ~clk;

  seq_add_sub #(.N(16), .CHUNK(4)) u_dut_c4 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]),
    .c_out(c_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]));

  seq_add_sub #(.N(16), .CHUNK(16)) u_dut_c16 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]),
    .c_out(c_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]));

  seq_add_sub #(.N(16), .CHUNK(1)) u_dut_c1 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]),
    .c_out(c_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]));

  // Reference built from integer arithmetic rather than chunked addition.
  function automatic res_t ref_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    res_t r;
    int   sa;
    int   sb;
    int   rs;
    sa     = int'($signed(a));
    sb     = int'($signed(b));
    rs     = s ? sa - sb : sa + sb;
    r.sum  = rs[15:0];
    r.c    = s ? (a >= b) : (({1'b0, a} + {1'b0, b}) > 17'h0FFFF);
    r.ovf  = (rs > 32767) || (rs < -32768);
    r.zero = (r.sum == 16'h0000);
    return r;
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Cycle model: update on the rising edge, compare on the falling edge.
  initial begin
    for (int i = 0; i < NI; i++) begin
      cnt[i]      = 0;
      ops_done[i] = 0;
      exp_done[i] = 1'b0;
      held[i]     = '0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        exp_done[i] = 1'b0;
        if (rst) begin
          cnt[i] = 0;
          q[i].delete();
          held[i] = '0;
        end else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            if (q[i].size() > 0) held[i] = q[i].pop_front();
            exp_done[i] = 1'b1;
            ops_done[i]++;
          end
        end else if (start) begin
          q[i].push_back(ref_op(A, B, sub));
          cnt[i] = LAT[i];
        end
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("cycle_inst%0d {done,busy,sum,c,ovf,zero}", i),
            {done_v[i], busy_v[i], sum_v[i], c_v[i], ovf_v[i], zero_v[i]},
            {exp_done[i], (cnt[i] > 0), held[i]});
      end
    end
  end

  vec_t tbl [6];

  initial begin
    int last_t;
    int nd;
    int cyc;
    int target;

    tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0}};
    tbl[1] = '{16'h0005, 16'h0007, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0}};
    tbl[2] = '{16'h0007, 16'h0007, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1}};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0}};
    tbl[4] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1}};
    tbl[5] = '{16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0}};

    rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset_inst%0d", i),
          {done_v[i], busy_v[i], sum_v[i], c_v[i], ovf_v[i], zero_v[i]}, 32'h0);
    rst = 1'b0;

    // Directed vectors, checked on all three chunk widths.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      A = tbl[v].a; B = tbl[v].b; sub = tbl[v].s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (18) @(negedge clk);
      for (int i = 0; i < NI; i++)
        chk($sformatf("vec%0d_inst%0d", v, i),
            {sum_v[i], c_v[i], ovf_v[i], zero_v[i]}, tbl[v].exp);
    end

    // start during RUN is ignored by the CHUNK=4 instance.
    @(negedge clk);
    A = 16'h1111; B = 16'h2222; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 16'hAAAA; B = 16'h5555; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("ignore_start_c4", {sum_v[0], c_v[0], ovf_v[0], zero_v[0]}, {16'h3333, 3'b000});

    // rst at RUN cycle 2 abandons the op; the next start completes normally.
    @(negedge clk);
    A = 16'h4321; B = 16'h1234; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_run_rst_c4",
        {done_v[0], busy_v[0], sum_v[0], c_v[0], ovf_v[0], zero_v[0]}, 32'h0);
    rst = 1'b0;
    A = 16'h0100; B = 16'h0001; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    chk("after_rst_c4", {sum_v[0], c_v[0], ovf_v[0], zero_v[0]}, {16'h00FF, 3'b100});

    // Back-to-back with start held high: one result every 5 cycles.
    last_t = -1;
    nd     = 0;
    start  = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom);
      if (done_v[0]) begin
        if (last_t >= 0) chk("b2b_gap_c4", c - last_t, 5);
        last_t = c;
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_count_c4", (nd >= 5), 1);
    repeat (20) @(negedge clk);

    // Random vectors with inputs changing every cycle, including during RUN.
    cyc    = 0;
    target = ops_done[0] + 1000;
    while (ops_done[0] < target && cyc < 20000) begin
      @(negedge clk);
      A = pick16(); B = pick16(); sub = 1'($urandom);
      start = ($urandom_range(0, 9) < 8);
      cyc++;
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("random_ops_completed", (ops_done[0] >= target), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
